// File: rtl/neural_network_pkg.sv
// Shared fixed-point definitions for the neuron datapath: Q7.8 sign-magnitude words,
// FSM state encoding and sign-magnitude <-> two's-complement helpers.
package neural_network_pkg;

  localparam int unsigned DATA_W  = 16;
  localparam int unsigned FRAC_W  = 8;
  localparam logic [14:0] MAG_MAX = 15'h7FFF;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    FINISH,
    OUTPUT
  } state_e;

  // -0 maps to 0; magnitude is at most 15 bits so the result always fits
  function automatic logic signed [DATA_W-1:0] sm_to_tc(input logic [DATA_W-1:0] sm);
    logic signed [DATA_W-1:0] mag;
    mag = signed'({1'b0, sm[DATA_W-2:0]});
    return sm[DATA_W-1] ? -mag : mag;
  endfunction

  // -32768 has no sign-magnitude image and clamps; zero is always returned as +0
  function automatic logic [DATA_W-1:0] tc_to_sm(input logic signed [DATA_W-1:0] tc);
    logic [DATA_W-1:0] mag;
    mag = tc[DATA_W-1] ? DATA_W'(-tc) : DATA_W'(tc);
    if (mag > {1'b0, MAG_MAX}) mag = {1'b0, MAG_MAX};
    if (mag == '0) return '0;
    return {tc[DATA_W-1], mag[DATA_W-2:0]};
  endfunction

endpackage

// File: rtl/sign_mag_mult.sv
// Combinational sign-magnitude multiplier: two Q7.8 operands in, signed Q14.16 product out.
module sign_mag_mult
  import neural_network_pkg::*;
(
  input  logic        [DATA_W-1:0]   i_a,
  input  logic        [DATA_W-1:0]   i_b,
  output logic signed [2*DATA_W-1:0] o_prod
);

  localparam int unsigned PROD_W = 2 * DATA_W;

  logic signed [DATA_W-1:0] w_a;
  logic signed [DATA_W-1:0] w_b;

  assign w_a    = sm_to_tc(i_a);
  assign w_b    = sm_to_tc(i_b);
  assign o_prod = PROD_W'(w_a) * PROD_W'(w_b);

endmodule

// File: rtl/neuron_mac.sv
// Sequential MAC neuron: accumulates N_INPUTS products, adds bias, emits a Q7.8 sign-magnitude
// result. Define NEURON_MAC_SAT_EN to saturate the magnitude instead of wrapping it.
module neuron_mac
  import neural_network_pkg::*;
#(
  parameter int unsigned N_INPUTS = 8,
  parameter int unsigned ACC_W    = 40
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic [DATA_W-1:0] in_weight,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] bias,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam int unsigned CNT_W = $clog2(N_INPUTS + 1);

  state_e                   r_state;
  logic        [CNT_W-1:0]  r_cnt;
  logic signed [ACC_W-1:0]  r_acc;
  logic                     r_in_ready;
  logic                     r_out_valid;
  logic        [DATA_W-1:0] r_out_data;

  logic signed [2*DATA_W-1:0] w_prod;
  logic                       w_beat;
  logic                       w_last;
  logic signed [ACC_W-1:0]    w_bias_ext;
  logic signed [ACC_W-1:0]    w_sum;
  logic        [ACC_W-1:0]    w_abs;
  logic        [ACC_W-1:0]    w_mag_full;
  logic        [DATA_W-2:0]   w_mag;
  logic        [DATA_W-1:0]   w_result;

  sign_mag_mult u_mult (
    .i_a    (in_data),
    .i_b    (in_weight),
    .o_prod (w_prod)
  );

  assign w_beat = in_valid & in_ready;
  assign w_last = (r_cnt == CNT_W'(N_INPUTS - 1));

  // Bias is Q7.8; shift to Q.16 to line up with the accumulated products
  assign w_bias_ext = ACC_W'(sm_to_tc(bias)) <<< FRAC_W;
  assign w_sum      = r_acc + w_bias_ext;
  assign w_abs      = w_sum[ACC_W-1] ? ACC_W'(-w_sum) : ACC_W'(w_sum);
  assign w_mag_full = w_abs >> FRAC_W;

`ifdef NEURON_MAC_SAT_EN
  assign w_mag = (|w_mag_full[ACC_W-1:DATA_W-1]) ? MAG_MAX : w_mag_full[DATA_W-2:0];
`else
  logic w_unused_mag_hi;
  assign w_unused_mag_hi = ^w_mag_full[ACC_W-1:DATA_W-1];
  assign w_mag           = w_mag_full[DATA_W-2:0];
`endif

  // Zero magnitude never carries a sign
  assign w_result = (w_mag == '0) ? '0 : {w_sum[ACC_W-1], w_mag};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_acc       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      unique case (r_state)
        IDLE, ACCUM: begin
          if (w_beat) begin
            r_acc <= r_acc + ACC_W'(w_prod);
            if (w_last) begin
              r_state    <= FINISH;
              r_cnt      <= '0;
              r_in_ready <= 1'b0;
            end else begin
              r_state <= ACCUM;
              r_cnt   <= r_cnt + CNT_W'(1);
            end
          end
        end
        FINISH: begin
          r_out_data  <= w_result;
          r_out_valid <= 1'b1;
          r_acc       <= '0;
          r_state     <= OUTPUT;
        end
        OUTPUT: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Held low combinationally during reset so no beat is taken while rst is asserted
  assign in_ready  = r_in_ready & ~rst;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;

endmodule

// File: tb/tb_neuron_mac.sv
// Self-checking bench for neuron_mac with N_INPUTS=4; expected results queued per operation.
module tb_neuron_mac;

  localparam int unsigned N = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] in_data;
  logic [15:0] in_weight;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] bias;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;

  int checks   = 0;
  int failures = 0;

  logic [15:0] exp_q[$];
  logic [15:0] op_d[N];
  logic [15:0] op_w[N];

  neuron_mac #(
    .N_INPUTS (N),
    .ACC_W    (40)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_weight (in_weight),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .bias      (bias),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic load_uniform(input logic [15:0] d, input logic [15:0] w);
    for (int i = 0; i < N; i++) begin
      op_d[i] = d;
      op_w[i] = w;
    end
  endtask

  task automatic drive_beats(input int nb, input bit gaps);
    for (int i = 0; i < nb; i++) begin
      if (gaps && i > 0) begin
        @(negedge clk);
        in_valid = 1'b0;
      end
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1) begin
        failures++;
        $display("FAIL in_ready_beat%0d got=%b exp=1", i, in_ready);
      end
      in_valid  = 1'b1;
      in_data   = op_d[i];
      in_weight = op_w[i];
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_result(input string name, input int stall);
    logic [15:0] held;
    logic [15:0] expv;
    int n;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL %s_lat1_out_valid got=%b exp=0", name, out_valid);
    end
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL %s_lat1_in_ready got=%b exp=0", name, in_ready);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1) begin
      failures++;
      $display("FAIL %s_lat2_out_valid got=%b exp=1", name, out_valid);
    end
    n = 0;
    while (out_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (out_valid !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout got=no_out_valid exp=out_valid", name);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      return;
    end
    held = out_data;
    for (int i = 0; i < stall; i++) begin
      // Offer garbage beats while stalled; none may be accepted
      in_valid  = i[0];
      in_data   = 16'h7F7F;
      in_weight = 16'h7F7F;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_data !== held) begin
        failures++;
        $display("FAIL %s_stall_hold got=%b/%h exp=1/%h", name, out_valid, out_data, held);
      end
      checks++;
      if (in_ready !== 1'b0) begin
        failures++;
        $display("FAIL %s_stall_in_ready got=%b exp=0", name, in_ready);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL %s_scoreboard got=unexpected_output exp=none", name);
    end else begin
      expv = exp_q.pop_front();
      if (out_data !== expv) begin
        failures++;
        $display("FAIL %s_out_data got=%h exp=%h", name, out_data, expv);
      end
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL %s_post_hs_out_valid got=%b exp=0", name, out_valid);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s_post_hs_in_ready got=%b exp=1", name, in_ready);
    end
  endtask

  task automatic run_op(input string name, input logic [15:0] b, input logic [15:0] expv,
                        input bit gaps, input int stall);
    bias      = b;
    out_ready = (stall == 0);
    exp_q.push_back(expv);
    drive_beats(N, gaps);
    wait_result(name, stall);
  endtask

  task automatic test_reset;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_weight = '0;
    bias      = '0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (out_data !== 16'h0000) begin
      failures++;
      $display("FAIL reset_out_data got=%h exp=0000", out_data);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_out_valid got=%b exp=0", out_valid);
    end
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_in_ready got=%b exp=0", in_ready);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release_in_ready got=%b exp=1", in_ready);
    end
  endtask

  task automatic test_basic_sum;
    load_uniform(16'h0100, 16'h0200);
    run_op("basic", 16'h0000, 16'h0800, 1'b0, 0);
  endtask

  task automatic test_signs_bias;
    load_uniform(16'h8100, 16'h0300);
    run_op("signs_bias_pos", 16'h0100, 16'h8B00, 1'b0, 0);
    run_op("signs_bias_negzero", 16'h8000, 16'h8C00, 1'b0, 0);
  endtask

  task automatic test_truncation_zero;
    load_uniform(16'h0001, 16'h0080);
    run_op("truncation", 16'h0000, 16'h0002, 1'b0, 0);
    load_uniform(16'h0100, 16'h0100);
    op_d[2] = 16'h8100;
    op_d[3] = 16'h8100;
    run_op("zero_sign", 16'h0000, 16'h0000, 1'b0, 0);
  endtask

  task automatic test_overflow;
    load_uniform(16'h7F00, 16'h7F00);
`ifdef NEURON_MAC_SAT_EN
    run_op("overflow", 16'h0000, 16'h7FFF, 1'b0, 0);
`else
    run_op("overflow", 16'h0000, 16'h0400, 1'b0, 0);
`endif
  endtask

  task automatic test_backpressure_gaps;
    load_uniform(16'h0100, 16'h0200);
    run_op("backpressure", 16'h0000, 16'h0800, 1'b1, 5);
  endtask

  task automatic test_back_to_back;
    load_uniform(16'h0200, 16'h8100);
    run_op("b2b_neg_frac", 16'h0080, 16'h8780, 1'b0, 0);
    load_uniform(16'h0180, 16'h0180);
    run_op("b2b_pos_frac", 16'h8000, 16'h0900, 1'b0, 0);
  endtask

  task automatic test_reset_mid;
    load_uniform(16'h0100, 16'h0200);
    bias      = 16'h0000;
    out_ready = 1'b1;
    drive_beats(2, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_out_valid got=%b exp=0", out_valid);
    end
    checks++;
    if (out_data !== 16'h0000) begin
      failures++;
      $display("FAIL reset_mid_out_data got=%h exp=0000", out_data);
    end
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_in_ready got=%b exp=0", in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    run_op("after_reset_mid", 16'h0000, 16'h0800, 1'b0, 0);
  endtask

  initial begin
    test_reset();
    test_basic_sum();
    test_signs_bias();
    test_truncation_zero();
    test_overflow();
    test_backpressure_gaps();
    test_back_to_back();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got=%0d exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/neuron_mac.md
# neuron_mac

Sequential multiply-accumulate neuron that sits directly upstream of the activation function. It consumes a stream of N_INPUTS (data, weight) pairs through a valid/ready handshake and accumulates their products at full precision. It then adds a bias, rescales and converts the sum to the 16-bit sign-magnitude fixed-point word the activation stage expects: bit 15 sign, bits 14:8 integer, bits 7:0 fraction.

## Interface
- N_INPUTS, 8: number of (data, weight) beats per neuron evaluation, range 1..256.
- ACC_W, 40: internal two's-complement accumulator width; must be ≥ 32 + clog2(N_INPUTS) + 1.
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_data  input  16  sign-magnitude activation input.
- in_weight  input  16  sign-magnitude weight.
- in_valid  input  1  the current in_data/in_weight pair is valid.
- in_ready  output  1  the block accepts a beat this cycle.
- bias  input  16  sign-magnitude bias; must be held stable from the first beat until out_valid.
- out_data  output  16  sign-magnitude result, fed to the activation function.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  the downstream stage accepts out_data.

## Operation
- Format: value = (-1)^s × mag / 256. Both -0 (0x8000) and +0 are read as zero.
- Each accepted beat (in_valid & in_ready) does three things:
  - converts both operands to two's complement;
  - forms the signed 32-bit product, Q14.16;
  - adds the product to the ACC_W accumulator.
- FSM states:
  - IDLE: in_ready=1, acc=0, cnt=0. On the first beat, go to ACCUM.
  - ACCUM: in_ready=1. cnt increments per beat. The beat that makes cnt==N_INPUTS moves the FSM to FINISH. With N_INPUTS=1, the first beat goes straight from IDLE to FINISH.
  - FINISH: one cycle, in_ready=0. Computes sum = acc + (bias << 8), takes |sum| >> 8 (truncation toward zero on the magnitude), attaches the sign and applies the overflow rule (see Configuration). Registers out_data and goes to OUTPUT.
  - OUTPUT: out_valid=1, in_ready=0. out_data is held until out_valid & out_ready, then the FSM goes to IDLE.
- A zero-magnitude result is always emitted as 0x0000, never 0x8000.
- in_valid may drop between beats. Gaps are allowed and cnt holds.
- Reset values: out_data=0x0000, out_valid=0, in_ready=0 while rst is high, FSM=IDLE, acc=0, cnt=0.
- Reset mid-operation discards the partial sum and the pending output. No output is ever produced from a partial operation.

## Timing
- Throughput: one beat per cycle while in ACCUM.
- Latency: out_valid rises 2 cycles after the clock edge that accepts the final beat (one edge for FINISH, one for OUTPUT).
- in_ready is 1 in the first cycle after rst deasserts. It is 0 from the cycle after the last beat until the cycle after the output handshake.
- No combinational path exists from out_ready to in_ready, or from in_valid to out_valid.
- Minimum period per evaluation: N_INPUTS + 2 cycles, plus any out_ready stall.

## Configuration
- NEURON_MAC_SAT_EN defined: a magnitude above 0x7FFF clamps to 0x7FFF and keeps its sign, giving ±127.996.
- NEURON_MAC_SAT_EN undefined: the magnitude keeps only its low 15 bits (wraps). This saves the compare logic.

## Structure
- Shared package neural_network_pkg holds:
  - DATA_W=16 and FRAC_W=8;
  - MAG_MAX=15'h7FFF;
  - the FSM state enum (IDLE, ACCUM, FINISH, OUTPUT);
  - functions sm_to_tc and tc_to_sm, which the activation and later stages reuse.
- One sub-module, sign_mag_mult: combinational. Takes two 16-bit sign-magnitude operands and returns a signed 32-bit Q14.16 product. It is instantiated once in neuron_mac.

## Test plan
All scenarios use N_INPUTS=4 and out_ready=1 unless stated.
- Basic sum: data 0x0100 and weight 0x0200 on all 4 beats, bias 0x0000 -> out_data 0x0800 (8.0). out_valid rises exactly 2 cycles after the 4th beat.
- Signs and bias: data 0x8100, weight 0x0300 on 4 beats, bias 0x0100 -> out_data 0x8B00 (-11.0). Repeat with bias 0x8000 -> out_data 0x8C00.
- Truncation and zero: data 0x0001, weight 0x0080 on 4 beats -> out_data 0x0002. Data 0x0100 and weight 0x0100 on 2 beats, then data 0x8100 and weight 0x0100 on 2 beats -> out_data 0x0000, not 0x8000.
- Overflow: data 0x7F00, weight 0x7F00 on 4 beats, bias 0 -> out_data 0x7FFF with NEURON_MAC_SAT_EN, 0x0400 without.
- Backpressure and gaps: in_valid toggles every other cycle and out_ready is held low for 5 cycles after out_valid. out_data stays stable, in_ready stays 0, and the result is unchanged. in_ready returns 1 the cycle after the handshake.
- Reset mid-operation: pulse rst after 2 beats -> out_valid=0 and out_data=0x0000 immediately. The next full 4-beat operation matches the basic-sum result 0x0800.
